// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock/tick dividers with per-channel enable,
// global phase-align and a glitch-free half-period update handshake.
module clk_div_bank #(
  parameter int unsigned NCH = 2,
  parameter int unsigned W = 25,
  parameter logic [NCH*W-1:0] DEF_HALF = {25'd9999, 25'd24999999},
  parameter int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           cfg_valid,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_half,
  output logic           cfg_ready,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] accept;

  // Out-of-range channel selects fall through with ready held high.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CW'(i)) cfg_ready = ~pending[i];
    end
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < NCH; i++) begin
      accept[i] = cfg_valid && (cfg_ch == CW'(i)) && !pending[i];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [W-1:0] cnt;
    logic [W-1:0] half;
    logic [W-1:0] shadow;
    logic         pend;
    logic         clk_q;
    logic         tick_q;
    logic         idle;
    logic         wrap;

    assign idle = sync || !en[g];
    assign wrap = !idle && (cnt == half);

    // Staged half-period only moves into the active slot when the counter is at 0.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt    <= '0;
        half   <= DEF_HALF[g*W +: W];
        shadow <= DEF_HALF[g*W +: W];
        pend   <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (accept[g]) begin
          shadow <= cfg_half;
          pend   <= 1'b1;
        end
        if ((idle || wrap) && pend) begin
          half <= shadow;
          pend <= 1'b0;
        end
        if (idle) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (wrap) begin
          cnt    <= '0;
          clk_q  <= ~clk_q;
          tick_q <= 1'b1;
        end else begin
          cnt    <= cnt + W'(1);
          tick_q <= 1'b0;
        end
      end
    end

    assign pending[g] = pend;
    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a behavioural reference pushes expected
// outputs to a scoreboard queue, popped and compared after each edge.
module tb_clk_div_bank;
  localparam int unsigned NCH = 2;
  localparam int unsigned W = 8;
  localparam int unsigned CW = 1;
  localparam logic [NCH*W-1:0] DEF = {8'd1, 8'd3};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           sync = 1'b0;
  logic           cfg_valid = 1'b0;
  logic [CW-1:0]  cfg_ch = '0;
  logic [W-1:0]   cfg_half = '0;
  logic           cfg_ready;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  always #5 clk = ~clk;

  clk_div_bank #(.NCH(NCH), .W(W), .DEF_HALF(DEF), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_ready(cfg_ready),
    .clk_out(clk_out), .tick(tick)
  );

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  // Reference state: phase counter, active/staged half-period, pending flag.
  logic [7:0] m_cnt[NCH];
  logic [7:0] m_half[NCH];
  logic [7:0] m_shadow[NCH];
  logic [1:0] m_pend = 2'bxx;
  logic [1:0] m_clk = 2'b00;
  logic [1:0] m_tick = 2'b00;

  logic [1:0] obs_clk;
  logic [1:0] obs_tick;
  logic       obs_rdy;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] e, input logic s,
                      input logic v, input logic c, input logic [7:0] h);
    logic       exp_rdy;
    logic       acc;
    logic       still;
    logic       edge_hit;
    logic [3:0] e4;
    rst = r; en = e; sync = s; cfg_valid = v; cfg_ch = c; cfg_half = h;
    #1;
    exp_rdy = !m_pend[c];
    obs_rdy = cfg_ready;
    if (!$isunknown(exp_rdy)) chk("cfg_ready", 8'(obs_rdy), 8'(exp_rdy));
    for (int i = 0; i < NCH; i++) begin
      acc = v && (c == 1'(i)) && (m_pend[i] == 1'b0);
      if (r) begin
        m_cnt[i] = 8'd0;
        m_half[i] = DEF[i*W +: W];
        m_shadow[i] = DEF[i*W +: W];
        m_pend[i] = 1'b0;
        m_clk[i] = 1'b0;
        m_tick[i] = 1'b0;
      end else begin
        still = s || !e[i];
        edge_hit = !still && (m_cnt[i] == m_half[i]);
        if ((still || edge_hit) && m_pend[i]) begin
          m_half[i] = m_shadow[i];
          m_pend[i] = 1'b0;
        end
        m_tick[i] = edge_hit;
        if (still) m_clk[i] = 1'b0;
        else if (edge_hit) m_clk[i] = ~m_clk[i];
        m_cnt[i] = (still || edge_hit) ? 8'd0 : m_cnt[i] + 8'd1;
        if (acc) begin
          m_shadow[i] = h;
          m_pend[i] = 1'b1;
        end
      end
    end
    exp_q.push_back({m_clk, m_tick});
    @(posedge clk);
    #1;
    obs_clk = clk_out;
    obs_tick = tick;
    e4 = exp_q.pop_front();
    chk("clk_out", 8'(obs_clk), 8'(e4[3:2]));
    chk("tick", 8'(obs_tick), 8'(e4[1:0]));
  endtask

  initial begin
    // Reset with enables already high: everything must stay low.
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("rst_outputs", 8'({obs_clk, obs_tick}), 8'd0);
    chk("rst_ready", 8'(obs_rdy), 8'd1);

    // Free run from default halves (ch0=3, ch1=1).
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
      if (k == 2) chk("ch1_first_rise", 8'(obs_clk[1]), 8'd1);
      if (k == 3) chk("ch0_before_rise", 8'(obs_clk[0]), 8'd0);
      if (k == 4) chk("ch0_first_rise", 8'({obs_clk[0], obs_tick[0]}), 8'd3);
    end

    // ch0 at cnt=1: program half=0; old period must finish first.
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'd0);
    chk("cfg_accept_rdy", 8'(obs_rdy), 8'd1);
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("pending_rdy_low", 8'(obs_rdy), 8'd0);
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("old_period_toggle", 8'({obs_clk[0], obs_tick[0]}), 8'd3);
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("rdy_after_apply", 8'(obs_rdy), 8'd1);
    chk("half0_toggle_a", 8'({obs_clk[0], obs_tick[0]}), 8'd1);
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("half0_toggle_b", 8'({obs_clk[0], obs_tick[0]}), 8'd3);

    // Stall on pending ch0 while ch1 request proceeds.
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'd3);
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'd2);
    chk("ch0_stall_a", 8'(obs_rdy), 8'd0);
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'd2);
    chk("ch0_accept_b", 8'(obs_rdy), 8'd1);
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'd1);
    chk("ch0_stall_c", 8'(obs_rdy), 8'd0);
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'd1);
    chk("ch0_stall_d", 8'(obs_rdy), 8'd0);
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 8'd3);
    chk("ch1_accept", 8'(obs_rdy), 8'd1);
    for (int k = 0; k < 10; k++) step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'd3);
    for (int k = 0; k < 10; k++) step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);

    // Phase-align with both halves at 3.
    step(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("sync_clear", 8'({obs_clk, obs_tick}), 8'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
      if (k == 3) chk("sync_hold_low", 8'(obs_clk), 8'd0);
      if (k == 4) chk("sync_aligned", 8'({obs_clk, obs_tick}), 8'hf);
    end

    // Disable ch1 with an update pending; it applies while disabled.
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 8'd0);
      chk("dis_ch1_low", 8'({obs_clk[1], obs_tick[1]}), 8'd0);
      if (k == 1) chk("dis_pending_rdy", 8'(obs_rdy), 8'd0);
      if (k == 2) chk("dis_applied_rdy", 8'(obs_rdy), 8'd1);
    end
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("reenable_first", 8'({obs_clk[1], obs_tick[1]}), 8'd3);
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("reenable_second", 8'({obs_clk[1], obs_tick[1]}), 8'd1);

    // Reprogram, then reset mid-operation: defaults and clear pending.
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'd5);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("midrst_outputs", 8'({obs_clk, obs_tick}), 8'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
      if (k == 1) chk("midrst_rdy", 8'(obs_rdy), 8'd1);
      if (k == 4) chk("midrst_default", 8'({obs_clk, obs_tick}), 8'h7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of NCH independent clock/tick dividers, each with a run-time programmable half-period, per-channel enable, single-cycle tick strobe and a global phase-align input. It is the next-generation divider for the design: it supplies the slow display/blink clocks and the scan-rate clocks from the single system clock. Divisor changes are glitch-free and are applied only at a channel's period boundary.

## Interface
- NCH, 2: number of divider channels (1..16).
- W, 25: counter and half-period width in bits.
- DEF_HALF, {25'd9999, 25'd24999999}: packed NCH*W reset half-period values. Channel i uses bits [i*W +: W].
- CW, $clog2(NCH) (min 1): width of cfg_ch.

- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  NCH  per-channel run enable.
- sync  in  1  one-cycle pulse that phase-aligns all channels.
- cfg_valid  in  1  half-period update request.
- cfg_ch  in  CW  target channel. Values ≥ NCH are ignored; cfg_ready is 1 for them.
- cfg_half  in  W  new half-period value.
- cfg_ready  out  1  combinational: ~pending[cfg_ch].
- clk_out  out  NCH  divided square-wave outputs (registered).
- tick  out  NCH  one-cycle strobe at each clk_out toggle (registered).

## Operation
- Per-channel state:
  - cnt[W]: counter.
  - half[W]: active half-period.
  - shadow[W]: staged value.
  - pending: staged value waiting to be applied.
  - clk_out and tick.
- Reset (rst=1 at an edge):
  - cnt=0, clk_out=0, tick=0.
  - half = DEF_HALF slice, shadow = DEF_HALF slice, pending=0.
- Counting (en[i]=1, no sync):
  - If cnt==half: cnt<=0, clk_out<=~clk_out, tick<=1. If pending is set, half<=shadow and pending<=0.
  - Otherwise: cnt<=cnt+1, tick<=0.
- Output period is 2*(half+1) clk cycles, at 50% duty. half=0 toggles clk_out every cycle, with tick continuously high.
- Disabled (en[i]=0):
  - cnt<=0, clk_out<=0, tick<=0.
  - If pending is set, half<=shadow and pending<=0, so the update applies on the next cycle.
  - Re-enabling starts a fresh period from cnt=0, with clk_out low.
- sync=1:
  - All channels: cnt<=0, clk_out<=0, tick<=0.
  - Pending updates apply at this edge.
  - sync overrides counting but not rst. After sync, enabled channels with equal half toggle on the same edge.
- Config handshake:
  - A transfer occurs when cfg_valid & cfg_ready at an edge: shadow[cfg_ch]<=cfg_half, pending<=1.
  - While pending is set, further requests to that channel stall (cfg_ready=0). Requests to other channels proceed.
  - cfg_valid with cfg_ch ≥ NCH completes and is discarded.
- Simultaneous accept and apply on the same channel cannot occur, because ready=0 while pending.
- The counter never exceeds half, since half only changes when cnt returns to 0. Lowering half mid-period cannot cause a wrap-around skip.

## Timing
- After rst deasserts with en=1, the first clk_out rise and tick occur at the edge half+1 cycles later.
  - Example: with half=3, cnt reads 0,1,2,3, and clk_out=1 and tick=1 are visible after edge 4.
- tick is high for exactly one cycle per toggle, coincident with clk_out changing.
- Config latency: accepted at edge A, the new half takes effect at the first period boundary after A (or at edge A+1 if the channel is disabled). cfg_ready returns high the cycle after the apply.
- Default configuration: channel 0 toggles every 25,000,000 cycles; channel 1 toggles every 10,000 cycles.
- rst mid-period discards the count and any pending update (half returns to DEF_HALF).

## Test plan
- NCH=2, W=8, DEF_HALF={8'd1,8'd3}, en=2'b11, release rst:
  - ch0 toggles every 4 cycles, ch1 every 2 cycles.
  - Each tick is one cycle wide.
  - All outputs are 0 during rst.
- While ch0 is mid-period (cnt=1), accept cfg_ch=0, cfg_half=0:
  - cfg_ready drops to 0.
  - The old period completes (toggle at cnt=3).
  - Afterwards ch0 toggles every cycle with tick stuck high; cfg_ready returns to 1.
- With pending set on ch0, hold cfg_valid to ch0 and then to ch1:
  - The ch0 request stalls until the apply.
  - The ch1 request is accepted in 1 cycle; ch1 applies at its own boundary.
- Pulse sync while ch0 cnt=2 and ch1 cnt=1:
  - Next cycle: both cnt=0, clk_out=00.
  - With both halves set to 3, both channels toggle together 4 edges later.
- Drop en[1] for 5 cycles with a ch1 update pending:
  - clk_out[1]=0 and tick[1]=0 while disabled.
  - The update applies one cycle after en[1] falls.
  - On re-enable, the first toggle comes after new_half+1 cycles.
- Assert rst for 1 cycle mid-operation after reprogramming:
  - All outputs return to 0, half returns to DEF_HALF, pending clears, cfg_ready=1.
